// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark embedding engine.
package wm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_IMG_ROWS = 256;
    localparam int DEF_IMG_COLS = 256;
    localparam int DEF_WM_ROWS  = 64;
    localparam int DEF_WM_COLS  = 64;
    localparam int DEF_WM_W     = 2;
    localparam int DEF_KEY_W    = 8;

    // Largest value representable in a w-bit pixel.
    function automatic logic [31:0] sat_limit(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/wm_blend.sv
// Combinational weighted blend of an image pixel with a watermark sample,
// scaled back to pixel width and saturated.
module wm_blend
    import wm_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int WM_W  = DEF_WM_W
) (
    input  logic [PIX_W-1:0] a1,
    input  logic [PIX_W-1:0] a2,
    input  logic [PIX_W-1:0] pix,
    input  logic [WM_W-1:0]  wm_s,
    output logic [PIX_W-1:0] pix_out
);

    localparam int SUM_W = 2 * PIX_W + 1;
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'(sat_limit(PIX_W));

    logic [PIX_W-1:0] ws;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] scaled;

    // The watermark sample is placed in the pixel's most significant bits.
    always_comb begin
        ws      = PIX_W'(wm_s) << (PIX_W - WM_W);
        sum     = SUM_W'(a1) * SUM_W'(pix) + SUM_W'(a2) * SUM_W'(ws);
        scaled  = sum >> PIX_W;
        pix_out = (scaled > LIMIT) ? LIMIT[PIX_W-1:0] : scaled[PIX_W-1:0];
    end

endmodule

// File: rtl/wm_embed_engine.sv
// Read-blend-write watermark embedder walking the image in raster order.
// Optional feature: define WM_KEY_SCRAMBLE_EN to XOR samples with a rotating key.
module wm_embed_engine
    import wm_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int IMG_ROWS = DEF_IMG_ROWS,
    parameter int IMG_COLS = DEF_IMG_COLS,
    parameter int WM_ROWS  = DEF_WM_ROWS,
    parameter int WM_COLS  = DEF_WM_COLS,
    parameter int WM_W     = DEF_WM_W,
    parameter int KEY_W    = DEF_KEY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [PIX_W-1:0]  a1,
    input  logic [PIX_W-1:0]  a2,
    input  logic [PIX_W-1:0]  IM_data_in,
    input  logic [WM_W-1:0]   WM_data_in,
    output logic [ADDR_W-1:0] Row_IM_addr,
    output logic [ADDR_W-1:0] Col_IM_addr,
    output logic [ADDR_W-1:0] Row_WM_addr,
    output logic [ADDR_W-1:0] Col_WM_addr,
    output logic              IM_RD_WRn,
    output logic              WM_RD_WRn,
    output logic [PIX_W-1:0]  IM_data_out,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'(IMG_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL    = ADDR_W'(IMG_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_WM_ROW = ADDR_W'(WM_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_WM_COL = ADDR_W'(WM_COLS - 1);

    state_t           state;
    logic [PIX_W-1:0] a1_r;
    logic [PIX_W-1:0] a2_r;
    logic [KEY_W-1:0] key_r;
    logic [WM_W-1:0]  wm_s;
    logic [PIX_W-1:0] pix_next;

`ifdef WM_KEY_SCRAMBLE_EN
    assign wm_s = WM_data_in ^ key_r[WM_W-1:0];
`else
    logic unused_key;
    assign unused_key = ^key_r;
    assign wm_s       = WM_data_in;
`endif

    assign WM_RD_WRn = 1'b1;

    wm_blend #(
        .PIX_W (PIX_W),
        .WM_W  (WM_W)
    ) u_blend (
        .a1      (a1_r),
        .a2      (a2_r),
        .pix     (IM_data_in),
        .wm_s    (wm_s),
        .pix_out (pix_next)
    );

    // Address registers double as the raster counters; the watermark pair
    // wraps on its own tile size so no modulo hardware is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a1_r        <= '0;
            a2_r        <= '0;
            key_r       <= '0;
            Row_IM_addr <= '0;
            Col_IM_addr <= '0;
            Row_WM_addr <= '0;
            Col_WM_addr <= '0;
            IM_RD_WRn   <= 1'b1;
            IM_data_out <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a1_r        <= a1;
                        a2_r        <= a2;
                        key_r       <= key;
                        Row_IM_addr <= '0;
                        Col_IM_addr <= '0;
                        Row_WM_addr <= '0;
                        Col_WM_addr <= '0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    IM_data_out <= pix_next;
                    IM_RD_WRn   <= 1'b0;
                    state       <= WR;
                end
                WR: begin
                    IM_RD_WRn <= 1'b1;
                    key_r     <= (key_r >> WM_W) | (key_r << (KEY_W - WM_W));
                    state     <= RD;
                    if (Col_IM_addr == LAST_COL) begin
                        Col_IM_addr <= '0;
                        Col_WM_addr <= '0;
                        if (Row_IM_addr == LAST_ROW) begin
                            Row_IM_addr <= '0;
                            Row_WM_addr <= '0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            Row_IM_addr <= Row_IM_addr + 1'b1;
                            Row_WM_addr <= (Row_WM_addr == LAST_WM_ROW) ? '0 : Row_WM_addr + 1'b1;
                        end
                    end else begin
                        Col_IM_addr <= Col_IM_addr + 1'b1;
                        Col_WM_addr <= (Col_WM_addr == LAST_WM_COL) ? '0 : Col_WM_addr + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
